// File: rtl/i2c_accel_target.sv
// I2C target emulating an accelerometer register device: 64-byte map, auto-increment pointer, per-transaction axis snapshot.
// Optional build macro I2C_TGT_GLITCH_FILTER_EN adds a 3-sample stable filter on SCL/SDA after synchronization.
module i2c_accel_target #(
    parameter logic [6:0] ADDR7 = 7'h53,
    parameter logic [7:0] DEVID = 8'hE5
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    output logic        reg_wr_strobe,
    output logic [5:0]  reg_wr_addr,
    output logic [7:0]  reg_wr_data,
    output logic        busy
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_IGNORE
    } state_t;

    state_t      state_r;
    logic [1:0]  scl_sync_r;
    logic [1:0]  sda_sync_r;
    logic        scl_s;
    logic        sda_s;
    logic        scl_prev_r;
    logic        sda_prev_r;
    logic [7:0]  shift_r;
    logic [2:0]  cnt_r;
    logic [5:0]  ptr_r;
    logic        rw_r;
    logic        oe_next_r;
    logic        oe_dly_r;
    logic [47:0] snap_r;
    logic [7:0]  ram_r [0:63];
    logic [7:0]  rd_byte_s;
    logic [7:0]  byte_s;
    logic        writable_s;
    logic        scl_rise_s;
    logic        scl_fall_s;
    logic        start_s;
    logic        stop_s;

    // Two-flop synchronizers; reset to the idle (released) bus level
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            scl_sync_r <= 2'b11;
            sda_sync_r <= 2'b11;
        end else begin
            scl_sync_r <= {scl_sync_r[0], scl_in};
            sda_sync_r <= {sda_sync_r[0], sda_in};
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [2:0] scl_hist_r;
    logic [2:0] sda_hist_r;
    logic       scl_filt_r;
    logic       sda_filt_r;

    // Stable filter: output follows only after three equal consecutive samples
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            scl_hist_r <= 3'b111;
            sda_hist_r <= 3'b111;
            scl_filt_r <= 1'b1;
            sda_filt_r <= 1'b1;
        end else begin
            scl_hist_r <= {scl_hist_r[1:0], scl_sync_r[1]};
            sda_hist_r <= {sda_hist_r[1:0], sda_sync_r[1]};
            if (scl_hist_r == 3'b111) scl_filt_r <= 1'b1;
            else if (scl_hist_r == 3'b000) scl_filt_r <= 1'b0;
            if (sda_hist_r == 3'b111) sda_filt_r <= 1'b1;
            else if (sda_hist_r == 3'b000) sda_filt_r <= 1'b0;
        end
    end

    assign scl_s = scl_filt_r;
    assign sda_s = sda_filt_r;
`else
    assign scl_s = scl_sync_r[1];
    assign sda_s = sda_sync_r[1];
`endif

    // Previous conditioned levels for edge and START/STOP detection
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_prev_r <= scl_s;
            sda_prev_r <= sda_s;
        end
    end

    assign scl_rise_s = scl_s & ~scl_prev_r;
    assign scl_fall_s = ~scl_s & scl_prev_r;
    assign start_s    = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
    assign stop_s     = scl_s & scl_prev_r & ~sda_prev_r & sda_s;
    assign byte_s     = {shift_r[6:0], sda_s};

    // Register map read mux: identity, snapshot bytes, otherwise RAM
    always_comb begin
        rd_byte_s = ram_r[ptr_r];
        case (ptr_r)
            6'h00:   rd_byte_s = DEVID;
            6'h32:   rd_byte_s = snap_r[7:0];
            6'h33:   rd_byte_s = snap_r[15:8];
            6'h34:   rd_byte_s = snap_r[23:16];
            6'h35:   rd_byte_s = snap_r[31:24];
            6'h36:   rd_byte_s = snap_r[39:32];
            6'h37:   rd_byte_s = snap_r[47:40];
            default: rd_byte_s = ram_r[ptr_r];
        endcase
    end

    // Identity and sample registers are read-only
    always_comb begin
        writable_s = 1'b1;
        if (ptr_r == 6'h00) begin
            writable_s = 1'b0;
        end else if ((ptr_r >= 6'h32) && (ptr_r <= 6'h37)) begin
            writable_s = 1'b0;
        end else begin
            writable_s = 1'b1;
        end
    end

    // Protocol FSM with register file and registered outputs
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_r       <= ST_IDLE;
            shift_r       <= 8'h00;
            cnt_r         <= 3'd0;
            ptr_r         <= 6'd0;
            rw_r          <= 1'b0;
            oe_next_r     <= 1'b0;
            oe_dly_r      <= 1'b0;
            snap_r        <= 48'h0;
            sda_oe        <= 1'b0;
            busy          <= 1'b0;
            reg_wr_strobe <= 1'b0;
            reg_wr_addr   <= 6'd0;
            reg_wr_data   <= 8'h00;
            for (int i = 0; i < 64; i++) ram_r[i] <= 8'h00;
        end else begin
            reg_wr_strobe <= 1'b0;
            // SDA changes are delayed past the SCL fall to give data hold
            oe_dly_r <= scl_fall_s;
            if (oe_dly_r) sda_oe <= oe_next_r;
            if (start_s) begin
                state_r   <= ST_ADDR;
                cnt_r     <= 3'd0;
                sda_oe    <= 1'b0;
                oe_next_r <= 1'b0;
                oe_dly_r  <= 1'b0;
            end else if (stop_s) begin
                state_r   <= ST_IDLE;
                busy      <= 1'b0;
                sda_oe    <= 1'b0;
                oe_next_r <= 1'b0;
                oe_dly_r  <= 1'b0;
            end else if (scl_rise_s) begin
                case (state_r)
                    ST_ADDR: begin
                        shift_r <= byte_s;
                        cnt_r   <= cnt_r + 3'd1;
                        if (cnt_r == 3'd7) begin
                            if (byte_s[7:1] == ADDR7) begin
                                state_r <= ST_ADDR_ACK;
                                busy    <= 1'b1;
                                rw_r    <= byte_s[0];
                                if (byte_s[0]) snap_r <= {sample_z, sample_y, sample_x};
                            end else begin
                                state_r <= ST_IGNORE;
                                busy    <= 1'b0;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        cnt_r <= 3'd0;
                        if (rw_r) begin
                            state_r <= ST_RDATA;
                            shift_r <= rd_byte_s;
                        end else begin
                            state_r <= ST_PTR;
                        end
                    end
                    ST_PTR: begin
                        shift_r <= byte_s;
                        cnt_r   <= cnt_r + 3'd1;
                        if (cnt_r == 3'd7) begin
                            ptr_r   <= byte_s[5:0];
                            state_r <= ST_PTR_ACK;
                        end
                    end
                    ST_PTR_ACK, ST_WDATA_ACK: begin
                        cnt_r   <= 3'd0;
                        state_r <= ST_WDATA;
                    end
                    ST_WDATA: begin
                        shift_r <= byte_s;
                        cnt_r   <= cnt_r + 3'd1;
                        if (cnt_r == 3'd7) begin
                            if (writable_s) begin
                                ram_r[ptr_r]  <= byte_s;
                                reg_wr_strobe <= 1'b1;
                                reg_wr_addr   <= ptr_r;
                                reg_wr_data   <= byte_s;
                            end
                            ptr_r   <= ptr_r + 6'd1;
                            state_r <= ST_WDATA_ACK;
                        end
                    end
                    ST_RDATA: begin
                        shift_r <= {shift_r[6:0], 1'b0};
                        cnt_r   <= cnt_r + 3'd1;
                        if (cnt_r == 3'd7) begin
                            ptr_r   <= ptr_r + 6'd1;
                            state_r <= ST_RDATA_ACK;
                        end
                    end
                    ST_RDATA_ACK: begin
                        cnt_r <= 3'd0;
                        if (!sda_s) begin
                            state_r <= ST_RDATA;
                            shift_r <= rd_byte_s;
                        end else begin
                            state_r <= ST_IGNORE;
                            busy    <= 1'b0;
                        end
                    end
                    default: state_r <= state_r;
                endcase
            end else if (scl_fall_s) begin
                case (state_r)
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: oe_next_r <= 1'b1;
                    ST_RDATA: oe_next_r <= ~shift_r[7];
                    default:  oe_next_r <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_accel_target.sv
// Directed bench for i2c_accel_target: bit-banged I2C master with scoreboard queues and a bus monitor.
module tb_i2c_accel_target;

    logic        clk;
    logic        rst;
    logic        scl;
    logic        m_sda;
    logic        sda_in;
    logic        sda_oe;
    logic [15:0] sample_x;
    logic [15:0] sample_y;
    logic [15:0] sample_z;
    logic        reg_wr_strobe;
    logic [5:0]  reg_wr_addr;
    logic [7:0]  reg_wr_data;
    logic        busy;

    int checks;
    int errors;
    int wr_cnt;
    int wr_rd;
    int oe_cycles;
    int busy_cycles;
    int oe_bad;
    int oe_mark;
    int busy_mark;
    logic        prev_oe;
    logic [13:0] wr_log [0:15];
    logic        ack_q [$];
    logic [7:0]  rd_q [$];
    logic [13:0] exp_wr_q [$];

    assign sda_in = m_sda & ~sda_oe;

    i2c_accel_target dut (
        .clk_clk       (clk),
        .reset_reset   (rst),
        .scl_in        (scl),
        .sda_in        (sda_in),
        .sda_oe        (sda_oe),
        .sample_x      (sample_x),
        .sample_y      (sample_y),
        .sample_z      (sample_z),
        .reg_wr_strobe (reg_wr_strobe),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus monitor: logs write strobes, counts driven/busy cycles and illegal SDA pull-downs
    initial begin
        wr_cnt = 0; oe_cycles = 0; busy_cycles = 0; oe_bad = 0; prev_oe = 1'b0;
    end
    always @(negedge clk) begin
        if (reg_wr_strobe) begin
            if (wr_cnt < 16) wr_log[wr_cnt] <= {reg_wr_addr, reg_wr_data};
            wr_cnt <= wr_cnt + 1;
        end
        if (sda_oe) oe_cycles <= oe_cycles + 1;
        if (busy) busy_cycles <= busy_cycles + 1;
        if (sda_oe && !prev_oe && scl) oe_bad <= oe_bad + 1;
        prev_oe <= sda_oe;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        clks(12); m_sda = 1'b1;
        clks(12); scl = 1'b1;
        clks(12); m_sda = 1'b0;
        clks(12); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        clks(12); m_sda = 1'b0;
        clks(12); scl = 1'b1;
        clks(12); m_sda = 1'b1;
        clks(24);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
        logic got;
        ack_q.push_back(exp_ack);
        for (int i = 7; i >= 0; i--) begin
            clks(12); m_sda = b[i];
            clks(12); scl = 1'b1;
            clks(24); scl = 1'b0;
        end
        clks(12); m_sda = 1'b1;
        clks(12); scl = 1'b1;
        clks(12); got = ~sda_in;
        clks(12); scl = 1'b0;
        chk(tag, {31'd0, got}, {31'd0, ack_q.pop_front()});
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic mack, input string tag);
        logic [7:0] d;
        d = 8'h00;
        rd_q.push_back(exp);
        for (int i = 0; i < 8; i++) begin
            clks(12); m_sda = 1'b1;
            clks(12); scl = 1'b1;
            clks(12); d = {d[6:0], sda_in};
            clks(12); scl = 1'b0;
        end
        clks(12); m_sda = ~mack;
        clks(12); scl = 1'b1;
        clks(24); scl = 1'b0;
        chk(tag, {24'd0, d}, {24'd0, rd_q.pop_front()});
    endtask

    task automatic check_writes();
        logic [13:0] e;
        while (exp_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front();
            if (wr_rd < 16) chk("wr_strobe", {18'd0, wr_log[wr_rd]}, {18'd0, e});
            else chk("wr_strobe_missing", 32'd0, {18'd0, e});
            wr_rd++;
        end
        chk("wr_count", wr_cnt, wr_rd);
    endtask

    initial begin
        checks = 0; errors = 0; wr_rd = 0;
        rst = 1'b1; scl = 1'b1; m_sda = 1'b1;
        sample_x = 16'h0000; sample_y = 16'h0000; sample_z = 16'h0000;
        clks(5);
        chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_strobe", {31'd0, reg_wr_strobe}, 32'd0);
        chk("rst_wr_addr", {26'd0, reg_wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, reg_wr_data}, 32'd0);
        rst = 1'b0;
        clks(5);

        // Write 0xAA, 0x55 starting at 0x10
        i2c_start();
        send_byte(8'hA6, 1'b1, "t1_addr_ack");
        chk("t1_busy_high", {31'd0, busy}, 32'd1);
        send_byte(8'h10, 1'b1, "t1_ptr_ack");
        exp_wr_q.push_back({6'h10, 8'hAA});
        send_byte(8'hAA, 1'b1, "t1_d0_ack");
        exp_wr_q.push_back({6'h11, 8'h55});
        send_byte(8'h55, 1'b1, "t1_d1_ack");
        i2c_stop();
        chk("t1_busy_low", {31'd0, busy}, 32'd0);
        check_writes();

        // Read back 0x10/0x11 through a repeated START
        i2c_start();
        send_byte(8'hA6, 1'b1, "t1b_addr_ack");
        send_byte(8'h10, 1'b1, "t1b_ptr_ack");
        i2c_start();
        send_byte(8'hA7, 1'b1, "t1b_raddr_ack");
        read_byte(8'hAA, 1'b1, "t1b_rd0");
        read_byte(8'h55, 1'b0, "t1b_rd1");
        i2c_stop();

        // DEVID then register 0x01; SDA released after NACK
        i2c_start();
        send_byte(8'hA6, 1'b1, "t2_addr_ack");
        send_byte(8'h00, 1'b1, "t2_ptr_ack");
        i2c_start();
        send_byte(8'hA7, 1'b1, "t2_raddr_ack");
        read_byte(8'hE5, 1'b1, "t2_devid");
        read_byte(8'h00, 1'b0, "t2_reg01");
        clks(12);
        chk("t2_oe_after_nack", {31'd0, sda_oe}, 32'd0);
        chk("t2_busy_after_nack", {31'd0, busy}, 32'd0);
        i2c_stop();

        // Coherent snapshot across a six-byte burst with samples changing mid-burst
        sample_x = 16'h1234; sample_y = 16'hFF80; sample_z = 16'h0100;
        i2c_start();
        send_byte(8'hA6, 1'b1, "t3_addr_ack");
        send_byte(8'h32, 1'b1, "t3_ptr_ack");
        i2c_start();
        send_byte(8'hA7, 1'b1, "t3_raddr_ack");
        read_byte(8'h34, 1'b1, "t3_xlo");
        sample_x = 16'hDEAD; sample_y = 16'hBEEF; sample_z = 16'hCAFE;
        read_byte(8'h12, 1'b1, "t3_xhi");
        read_byte(8'h80, 1'b1, "t3_ylo");
        read_byte(8'hFF, 1'b1, "t3_yhi");
        read_byte(8'h00, 1'b1, "t3_zlo");
        read_byte(8'h01, 1'b0, "t3_zhi");
        i2c_stop();

        // Foreign address 0x1D: never acknowledged, never driven, never busy
        oe_mark = oe_cycles; busy_mark = busy_cycles;
        i2c_start();
        send_byte(8'h3A, 1'b0, "t4_addr_nack");
        send_byte(8'h10, 1'b0, "t4_b0_nack");
        send_byte(8'hA6, 1'b0, "t4_b1_nack");
        send_byte(8'h00, 1'b0, "t4_b2_nack");
        i2c_stop();
        chk("t4_oe_cycles", oe_cycles, oe_mark);
        chk("t4_busy_cycles", busy_cycles, busy_mark);

        // Pointer wrap 0x3F -> 0x00, read-only 0x00 not strobed
        i2c_start();
        send_byte(8'hA6, 1'b1, "t5_addr_ack");
        send_byte(8'h3F, 1'b1, "t5_ptr_ack");
        exp_wr_q.push_back({6'h3F, 8'h11});
        send_byte(8'h11, 1'b1, "t5_d0_ack");
        send_byte(8'h22, 1'b1, "t5_d1_ack");
        i2c_stop();
        check_writes();
        i2c_start();
        send_byte(8'hA7, 1'b1, "t5_raddr_ack");
        read_byte(8'h00, 1'b0, "t5_rd_ptr01");
        i2c_stop();
        i2c_start();
        send_byte(8'hA6, 1'b1, "t5b_addr_ack");
        send_byte(8'h3F, 1'b1, "t5b_ptr_ack");
        i2c_start();
        send_byte(8'hA7, 1'b1, "t5b_raddr_ack");
        read_byte(8'h11, 1'b1, "t5b_rd3f");
        read_byte(8'hE5, 1'b0, "t5b_rd_wrap");
        i2c_stop();

        // Asynchronous reset while the target drives bit 4 (a zero) of DEVID
        i2c_start();
        send_byte(8'hA6, 1'b1, "t6_addr_ack");
        send_byte(8'h00, 1'b1, "t6_ptr_ack");
        i2c_start();
        send_byte(8'hA7, 1'b1, "t6_raddr_ack");
        for (int i = 0; i < 3; i++) begin
            clks(12); m_sda = 1'b1;
            clks(12); scl = 1'b1;
            clks(24); scl = 1'b0;
        end
        clks(12);
        chk("t6_oe_before_rst", {31'd0, sda_oe}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_oe_async_rst", {31'd0, sda_oe}, 32'd0);
        chk("t6_busy_rst", {31'd0, busy}, 32'd0);
        clks(3);
        rst = 1'b0;
        scl = 1'b1;
        clks(24);
        i2c_start();
        send_byte(8'hA6, 1'b1, "t6_post_addr_ack");
        send_byte(8'h10, 1'b1, "t6_post_ptr_ack");
        i2c_start();
        send_byte(8'hA7, 1'b1, "t6_post_raddr_ack");
        read_byte(8'h00, 1'b0, "t6_ram_cleared");
        i2c_stop();
        check_writes();
        chk("oe_rise_scl_high", oe_bad, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
